// File: rtl/clock_ctrl_pkg.sv
// Shared types for the clock set controller.
// Mode encoding, BCD digit type, field limits, mode sequencing.
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_HOUR = 2'd1,
    MODE_SET_MIN  = 2'd2,
    MODE_SET_SEC  = 2'd3
  } mode_t;

  typedef logic [3:0] bcd_t;

  localparam int HOUR_MAX   = 23;
  localparam int MINSEC_MAX = 59;

  function automatic mode_t next_mode(input mode_t m);
    mode_t n;
    case (m)
      MODE_RUN:      n = MODE_SET_HOUR;
      MODE_SET_HOUR: n = MODE_SET_MIN;
      MODE_SET_MIN:  n = MODE_SET_SEC;
      default:       n = MODE_RUN;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter modulo MAX+1 with inc/dec and wrap.
// Ports: clk, reset, inc, dec -> tens, ones, carry_out (MAX->0 on inc).
module bcd_mod_counter
  import clock_ctrl_pkg::*;
#(
  parameter int MAX = 59
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output bcd_t tens,
  output bcd_t ones,
  output logic carry_out
);

  localparam bcd_t MAX_T = bcd_t'(MAX / 10);
  localparam bcd_t MAX_O = bcd_t'(MAX % 10);

  logic at_max;
  logic at_zero;
  logic do_inc;
  logic do_dec;

  assign at_max  = (tens == MAX_T) && (ones == MAX_O);
  assign at_zero = (tens == 4'd0) && (ones == 4'd0);
  assign do_inc  = inc && !dec;
  assign do_dec  = dec && !inc;

  // Combinational so a full rollover settles in one cycle.
  assign carry_out = do_inc && at_max;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tens <= 4'd0;
      ones <= 4'd0;
    end else if (do_inc) begin
      if (at_max) begin
        tens <= 4'd0;
        ones <= 4'd0;
      end else if (ones == 4'd9) begin
        tens <= tens + 4'd1;
        ones <= 4'd0;
      end else begin
        ones <= ones + 4'd1;
      end
    end else if (do_dec) begin
      if (at_zero) begin
        tens <= MAX_T;
        ones <= MAX_O;
      end else if (ones == 4'd0) begin
        tens <= tens - 4'd1;
        ones <= 4'd9;
      end else begin
        ones <= ones - 4'd1;
      end
    end
  end

endmodule

// File: rtl/clock_set_controller.sv
// HH:MM:SS keeper with RUN / SET_HOUR / SET_MIN / SET_SEC sequencing.
// Ports: clk, reset, tick_1hz, set/up/down pulses -> six BCD digits,
// mode, digit_blank. CLOCK_SET_BLINK_EN enables set-mode field blink.
module clock_set_controller
  import clock_ctrl_pkg::*;
#(
  parameter int BLINK_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       set_pulse,
  input  logic       up_pulse,
  input  logic       down_pulse,
  output logic [3:0] hour_tens,
  output logic [3:0] hour_ones,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [1:0] mode,
  output logic [5:0] digit_blank
);

  mode_t mode_q;
  logic  run;
  logic  ud_ok;
  logic  sec_inc, sec_dec, sec_c;
  logic  min_inc, min_dec, min_c;
  logic  hour_inc, hour_dec;
  logic  unused_hour_carry;

  assign run = (mode_q == MODE_RUN);

  // set wins; up+down together cancel.
  assign ud_ok = !run && !set_pulse && (up_pulse ^ down_pulse);

  assign sec_inc  = run ? tick_1hz
                  : ud_ok && up_pulse && (mode_q == MODE_SET_SEC);
  assign sec_dec  = ud_ok && down_pulse && (mode_q == MODE_SET_SEC);
  assign min_inc  = run ? sec_c
                  : ud_ok && up_pulse && (mode_q == MODE_SET_MIN);
  assign min_dec  = ud_ok && down_pulse && (mode_q == MODE_SET_MIN);
  assign hour_inc = run ? min_c
                  : ud_ok && up_pulse && (mode_q == MODE_SET_HOUR);
  assign hour_dec = ud_ok && down_pulse && (mode_q == MODE_SET_HOUR);

  bcd_mod_counter #(.MAX(MINSEC_MAX)) u_sec (
    .clk       (clk),
    .reset     (reset),
    .inc       (sec_inc),
    .dec       (sec_dec),
    .tens      (sec_tens),
    .ones      (sec_ones),
    .carry_out (sec_c)
  );

  bcd_mod_counter #(.MAX(MINSEC_MAX)) u_min (
    .clk       (clk),
    .reset     (reset),
    .inc       (min_inc),
    .dec       (min_dec),
    .tens      (min_tens),
    .ones      (min_ones),
    .carry_out (min_c)
  );

  bcd_mod_counter #(.MAX(HOUR_MAX)) u_hour (
    .clk       (clk),
    .reset     (reset),
    .inc       (hour_inc),
    .dec       (hour_dec),
    .tens      (hour_tens),
    .ones      (hour_ones),
    .carry_out (unused_hour_carry)
  );

  // A tick in the same cycle as set is applied under RUN gating above.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q <= MODE_RUN;
    end else if (set_pulse) begin
      mode_q <= next_mode(mode_q);
    end
  end

  assign mode = mode_q;

`ifdef CLOCK_SET_BLINK_EN
  localparam int CW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_CYCLES - 1);

  logic [CW-1:0] blink_cnt, blink_cnt_d;
  logic          blink_ph, blink_ph_d;
  logic          restart;
  mode_t         mode_d;
  logic [5:0]    blank_d;

  // Restart shows digits immediately after any edit or mode change.
  assign restart = set_pulse || ud_ok;
  assign mode_d  = set_pulse ? next_mode(mode_q) : mode_q;

  always_comb begin
    blink_cnt_d = blink_cnt + CW'(1);
    blink_ph_d  = blink_ph;
    if (restart) begin
      blink_cnt_d = '0;
      blink_ph_d  = 1'b0;
    end else if (blink_cnt == CNT_LAST) begin
      blink_cnt_d = '0;
      blink_ph_d  = !blink_ph;
    end
    blank_d = 6'b0;
    case (mode_d)
      MODE_SET_HOUR: blank_d[5:4] = {2{blink_ph_d}};
      MODE_SET_MIN:  blank_d[3:2] = {2{blink_ph_d}};
      MODE_SET_SEC:  blank_d[1:0] = {2{blink_ph_d}};
      default:       blank_d      = 6'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_ph    <= 1'b0;
      digit_blank <= 6'b0;
    end else begin
      blink_cnt   <= blink_cnt_d;
      blink_ph    <= blink_ph_d;
      digit_blank <= blank_d;
    end
  end
`else
  logic unused_blink;
  assign unused_blink = (BLINK_CYCLES > 0);
  assign digit_blank  = 6'b0;
`endif

endmodule
